// File: rtl/sdram_pkg.sv
// Shared SDRAM pin-level definitions: command encoding, error codes, mode-register fields.
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_ACT_OPEN = 3'd1,
    ERR_CLOSED   = 3'd2,
    ERR_NO_MRS   = 3'd3,
    ERR_REF_OPEN = 3'd4,
    ERR_BAD_MRS  = 3'd5
  } err_code_e;

  localparam int MRS_BL_LSB = 0;
  localparam int MRS_BL_W   = 3;
  localparam int MRS_BT_BIT = 3;
  localparam int MRS_CL_LSB = 4;
  localparam int MRS_CL_W   = 3;
  localparam int MRS_WB_BIT = 9;
  localparam int AP_BIT     = 10;

  function automatic logic [3:0] bl_decode(input logic [MRS_BL_W-1:0] code);
    case (code)
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/sdram_chip_model_rd_pipe.sv
// Read return pipe: delays fetched beats CL-1 edges (CL 2/3); dqm seen 2 edges late.
// Frozen while en=0; flush drops every beat in flight.
module sdram_chip_model_rd_pipe
  import sdram_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            cl3,
  input  logic            in_vld,
  input  logic [DW-1:0]   in_dat,
  input  logic [DW/8-1:0] dqm,
  output logic            out_vld,
  output logic [DW-1:0]   out_dat,
  output logic [DW/8-1:0] out_mask
);

  logic [2:0]      vld;
  logic [DW-1:0]   dat [3];
  logic [DW/8-1:0] dqm_d1;
  logic [DW/8-1:0] dqm_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      dat[0] <= '0;
      dat[1] <= '0;
      dat[2] <= '0;
      dqm_d1 <= '0;
      dqm_d2 <= '0;
    end else if (en) begin
      vld    <= flush ? 3'b000 : {vld[1:0], in_vld};
      dat[0] <= in_dat;
      dat[1] <= dat[0];
      dat[2] <= dat[1];
      dqm_d1 <= dqm;
      dqm_d2 <= dqm_d1;
    end
  end

  always_comb begin
    out_vld  = cl3 ? vld[2] : vld[1];
    out_dat  = cl3 ? dat[2] : dat[1];
    out_mask = dqm_d2;
  end

endmodule

// File: rtl/sdram_chip_model.sv
// SDRAM device-side responder: decodes commands, tracks banks/mode, stores writes, returns reads after CL.
// No backpressure; cke=0 freezes everything; violations pulse proto_err for one cycle.
module sdram_chip_model
  import sdram_pkg::*;
#(
  parameter int ROW_W  = 12,
  parameter int COL_W  = 8,
  parameter int BA_W   = 2,
  parameter int DW     = 16,
  parameter int MEM_AW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sdram_cke,
  input  logic            sdram_cs_n,
  input  logic            sdram_ras_n,
  input  logic            sdram_cas_n,
  input  logic            sdram_we_n,
  input  logic [ROW_W-1:0] sdram_addr,
  input  logic [BA_W-1:0] sdram_ba,
  input  logic [DW/8-1:0] sdram_dqm,
  inout  wire  [DW-1:0]   sdram_dq,
  output logic            proto_err,
  output logic [2:0]      proto_err_code
);

  localparam int NB = 1 << BA_W;
  localparam int LN = DW / 8;

  cmd_e             cmd;
  err_code_e        err;
  logic [NB-1:0]    bank_open;
  logic [ROW_W-1:0] bank_row [NB];
  logic             cl3;
  logic             wr_single;
  logic             mode_set;
  logic [3:0]       bl;

  logic             bst_act;
  logic             bst_wr;
  logic             bst_ap;
  logic [BA_W-1:0]  bst_ba;
  logic [ROW_W-1:0] bst_row;
  logic [COL_W-1:0] bst_col;
  logic [3:0]       bst_len;
  logic [3:0]       bst_idx;

  logic             rw_ok;
  logic             bst_stop;
  logic             beat_do;
  logic             beat_wr;
  logic             beat_last;
  logic [BA_W-1:0]  beat_ba;
  logic [ROW_W-1:0] beat_row;
  logic [COL_W-1:0] beat_base;
  logic [COL_W-1:0] beat_col;
  logic [COL_W-1:0] blm;
  logic [3:0]       beat_len;
  logic [3:0]       beat_k;
  logic [3:0]       new_len;
  logic [MEM_AW-1:0] beat_idx;
  logic [MRS_CL_W-1:0] mrs_cl;
  logic             cl_ok;

  logic [DW-1:0]    mem [1 << MEM_AW];
  logic [DW-1:0]    rd_dat;
  logic             rd_push;
  logic             wr_now;
  logic             pipe_vld;
  logic [DW-1:0]    pipe_dat;
  logic [LN-1:0]    pipe_mask;

  always_comb begin
    cmd    = sdram_cs_n ? CMD_NOP : cmd_e'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n});
    mrs_cl = sdram_addr[MRS_CL_LSB +: MRS_CL_W];
    cl_ok  = (mrs_cl == 3'd2) || (mrs_cl == 3'd3);
  end

  // At most one command per cycle, so only ACT can raise two codes; lowest is tested first.
  always_comb begin
    err = ERR_NONE;
    case (cmd)
      CMD_ACT: begin
        if (bank_open[sdram_ba])  err = ERR_ACT_OPEN;
        else if (!mode_set)       err = ERR_NO_MRS;
      end
      CMD_RD, CMD_WR: if (!bank_open[sdram_ba]) err = ERR_CLOSED;
      CMD_REF: if (|bank_open) err = ERR_REF_OPEN;
      CMD_MRS: begin
        if (sdram_addr[MRS_BL_LSB +: MRS_BL_W] > 3'd3 || sdram_addr[MRS_BT_BIT] || !cl_ok)
          err = ERR_BAD_MRS;
      end
      default: ;
    endcase
  end

  // A new accepted READ/WRITE supplies this edge's beat; otherwise the running burst does.
  always_comb begin
    rw_ok     = (cmd == CMD_RD || cmd == CMD_WR) && bank_open[sdram_ba];
    new_len   = (cmd == CMD_WR && wr_single) ? 4'd1 : bl;
    bst_stop  = (cmd == CMD_BST) ||
                (cmd == CMD_PRE && (sdram_addr[AP_BIT] || sdram_ba == bst_ba));
    beat_do   = rw_ok || (bst_act && !bst_stop);
    beat_wr   = rw_ok ? (cmd == CMD_WR) : bst_wr;
    beat_ba   = rw_ok ? sdram_ba : bst_ba;
    beat_row  = rw_ok ? bank_row[sdram_ba] : bst_row;
    beat_base = rw_ok ? sdram_addr[COL_W-1:0] : bst_col;
    beat_len  = rw_ok ? new_len : bst_len;
    beat_k    = rw_ok ? 4'd0 : bst_idx;
    blm       = COL_W'(beat_len - 4'd1);
    beat_col  = (beat_base & ~blm) | ((beat_base + COL_W'(beat_k)) & blm);
    beat_last = (beat_k == beat_len - 4'd1);
    beat_idx  = MEM_AW'({beat_ba, beat_row, beat_col});
    rd_dat    = mem[beat_idx];
    rd_push   = sdram_cke && beat_do && !beat_wr;
    wr_now    = sdram_cke && (cmd == CMD_WR);
  end

  always_ff @(posedge clk) begin
    if (sdram_cke && beat_do && beat_wr) begin
      for (int l = 0; l < LN; l++)
        if (!sdram_dqm[l]) mem[beat_idx][l*8 +: 8] <= sdram_dq[l*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open      <= '0;
      for (int b = 0; b < NB; b++) bank_row[b] <= '0;
      cl3            <= 1'b0;
      bl             <= 4'd1;
      wr_single      <= 1'b0;
      mode_set       <= 1'b0;
      bst_act        <= 1'b0;
      bst_wr         <= 1'b0;
      bst_ap         <= 1'b0;
      bst_ba         <= '0;
      bst_row        <= '0;
      bst_col        <= '0;
      bst_len        <= 4'd1;
      bst_idx        <= 4'd0;
      proto_err      <= 1'b0;
      proto_err_code <= 3'd0;
    end else if (!sdram_cke) begin
      proto_err      <= 1'b0;
      proto_err_code <= 3'd0;
    end else begin
      proto_err      <= (err != ERR_NONE);
      proto_err_code <= err;
      case (cmd)
        CMD_ACT: begin
          if (!bank_open[sdram_ba]) begin
            bank_open[sdram_ba] <= 1'b1;
            bank_row[sdram_ba]  <= sdram_addr;
          end
        end
        CMD_PRE: begin
          if (sdram_addr[AP_BIT]) bank_open <= '0;
          else                    bank_open[sdram_ba] <= 1'b0;
        end
        CMD_MRS: begin
          bl        <= bl_decode(sdram_addr[MRS_BL_LSB +: MRS_BL_W]);
          if (cl_ok) cl3 <= mrs_cl[0];
          wr_single <= sdram_addr[MRS_WB_BIT];
          mode_set  <= 1'b1;
        end
        default: ;
      endcase
      if (rw_ok) begin
        bst_act <= (new_len != 4'd1);
        bst_wr  <= (cmd == CMD_WR);
        bst_ap  <= sdram_addr[AP_BIT];
        bst_ba  <= sdram_ba;
        bst_row <= bank_row[sdram_ba];
        bst_col <= sdram_addr[COL_W-1:0];
        bst_len <= new_len;
        bst_idx <= 4'd1;
        if (new_len == 4'd1 && sdram_addr[AP_BIT]) bank_open[sdram_ba] <= 1'b0;
      end else if (bst_act) begin
        if (bst_stop || beat_last) bst_act <= 1'b0;
        if (!bst_stop && beat_last && bst_ap) bank_open[bst_ba] <= 1'b0;
        bst_idx <= bst_idx + 4'd1;
      end
    end
  end

  sdram_chip_model_rd_pipe #(.DW(DW)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (sdram_cke),
    .flush    (wr_now),
    .cl3      (cl3),
    .in_vld   (rd_push),
    .in_dat   (rd_dat),
    .dqm      (sdram_dqm),
    .out_vld  (pipe_vld),
    .out_dat  (pipe_dat),
    .out_mask (pipe_mask)
  );

  // Drive is released combinationally on reset or when the controller presents a WRITE.
  for (genvar l = 0; l < LN; l++) begin : g_lane
    assign sdram_dq[l*8 +: 8] = (pipe_vld && !pipe_mask[l] && !wr_now && !rst) ?
                                pipe_dat[l*8 +: 8] : 8'hzz;
  end

endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed bench for sdram_chip_model; dq has pullups so a released bus reads 16'hFFFF.
module tb_sdram_chip_model;

  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [15:0] Z16  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [11:0] addr;
  logic [1:0]  ba;
  logic [1:0]  dqm;
  wire  [15:0] dq;
  logic [15:0] tb_dq;
  logic        tb_dq_en;
  logic        proto_err;
  logic [2:0]  proto_err_code;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_a [4];
  logic [15:0] exp_b [5];

  assign dq = tb_dq_en ? tb_dq : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (dq[i]);
  end

  always #5 clk = ~clk;

  sdram_chip_model dut (
    .clk            (clk),
    .rst            (rst),
    .sdram_cke      (cke),
    .sdram_cs_n     (cs_n),
    .sdram_ras_n    (ras_n),
    .sdram_cas_n    (cas_n),
    .sdram_we_n     (we_n),
    .sdram_addr     (addr),
    .sdram_ba       (ba),
    .sdram_dqm      (dqm),
    .sdram_dq       (dq),
    .proto_err      (proto_err),
    .proto_err_code (proto_err_code)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba   = b;
    addr = a;
  endtask

  // Present one command for one edge, then return to NOP with dq released.
  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    set_cmd(c, b, a);
    tick();
    set_cmd(C_NOP, 2'd0, 12'h000);
    tb_dq_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cke = 1'b1; dqm = 2'b00; tb_dq = '0; tb_dq_en = 1'b0;
    set_cmd(C_NOP, 2'd0, 12'h000);
    repeat (3) tick();
    check("rst_err", {15'd0, proto_err}, 16'd0);
    check("rst_code", {13'd0, proto_err_code}, 16'd0);
    check("rst_dq", dq, Z16);
    rst = 1'b0;
    tick();

    // init: ACT before MRS is flagged but the bank still opens
    issue(C_ACT, 2'd0, 12'h000);
    check("act_before_mrs", {13'd0, proto_err_code}, 16'd3);
    issue(C_PRE, 2'd0, 12'h400);
    check("pre_all", {12'd0, proto_err, proto_err_code}, 16'd0);
    issue(C_REF, 2'd0, 12'h000);
    issue(C_REF, 2'd0, 12'h000);
    check("ref_closed", {12'd0, proto_err, proto_err_code}, 16'd0);
    issue(C_MRS, 2'd0, 12'h020);
    check("mrs_cl2_bl1", {12'd0, proto_err, proto_err_code}, 16'd0);

    // CL2 single-beat write/read
    issue(C_ACT, 2'd1, 12'h123);
    check("act_b1", {12'd0, proto_err, proto_err_code}, 16'd0);
    tb_dq = 16'hA5A5; tb_dq_en = 1'b1;
    issue(C_WR, 2'd1, 12'h010);
    issue(C_RD, 2'd1, 12'h010);
    check("cl2_n1_z", dq, Z16);
    tick(); check("cl2_n2_data", dq, 16'hA5A5);
    tick(); check("cl2_n3_z", dq, Z16);

    // CL3 BL4 wrap: write col 6 -> cols 6,7,4,5 hold 1,2,3,4
    issue(C_MRS, 2'd0, 12'h032);
    check("mrs_cl3_bl4", {12'd0, proto_err, proto_err_code}, 16'd0);
    set_cmd(C_WR, 2'd1, 12'h006); tb_dq = 16'd1; tb_dq_en = 1'b1;
    tick();
    set_cmd(C_NOP, 2'd0, 12'h000);
    for (int k = 2; k <= 4; k++) begin
      tb_dq = 16'(k);
      tick();
    end
    tb_dq_en = 1'b0;
    exp_a[0] = 16'd3; exp_a[1] = 16'd4; exp_a[2] = 16'd1; exp_a[3] = 16'd2;
    issue(C_RD, 2'd1, 12'h004);
    check("cl3_n1_z", dq, Z16);
    tick(); check("cl3_n2_z", dq, Z16);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("bl4_wrap_beat%0d", k), dq, exp_a[k]);
    end
    tick(); check("bl4_after_z", dq, Z16);

    // read mask: dqm at edge n+2 blanks the beat sampled at n+4
    issue(C_RD, 2'd1, 12'h004);
    tick();
    dqm = 2'b11;
    tick(); dqm = 2'b00;
    check("dqm_beat0", dq, 16'd3);
    tick(); check("dqm_beat1_z", dq, Z16);
    tick(); check("dqm_beat2", dq, 16'd1);
    tick(); check("dqm_beat3", dq, 16'd2);
    tick();

    // write byte mask with single-beat writes
    issue(C_MRS, 2'd0, 12'h232);
    tb_dq = 16'hFFFF; tb_dq_en = 1'b1;
    issue(C_WR, 2'd1, 12'h020);
    tb_dq = 16'h1234; tb_dq_en = 1'b1; dqm = 2'b10;
    issue(C_WR, 2'd1, 12'h020);
    dqm = 2'b00;
    issue(C_RD, 2'd1, 12'h020);
    tick(); tick();
    check("byte_mask", dq, 16'hFF34);
    repeat (4) tick();

    // protocol errors
    issue(C_RD, 2'd2, 12'h004);
    check("rd_closed_err", {15'd0, proto_err}, 16'd1);
    check("rd_closed_code", {13'd0, proto_err_code}, 16'd2);
    tick(); check("err_one_cycle", {15'd0, proto_err}, 16'd0);
    tick(); check("rd_closed_no_dq", dq, Z16);
    issue(C_ACT, 2'd1, 12'h055);
    check("act_open_code", {13'd0, proto_err_code}, 16'd1);
    issue(C_REF, 2'd0, 12'h000);
    check("ref_open_code", {13'd0, proto_err_code}, 16'd4);
    issue(C_MRS, 2'd0, 12'h072);
    check("bad_cl_code", {13'd0, proto_err_code}, 16'd5);

    // interrupted BL4 read (CL3 kept, row 0x123 kept)
    exp_b[0] = 16'd3; exp_b[1] = 16'd1; exp_b[2] = 16'd2; exp_b[3] = 16'd3; exp_b[4] = 16'd4;
    issue(C_RD, 2'd1, 12'h004);
    issue(C_RD, 2'd1, 12'h006);
    check("intr_n2_z", dq, Z16);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("intr_edge%0d", k + 3), dq, exp_b[k]);
    end

    // reset in the middle of a burst
    issue(C_RD, 2'd1, 12'h004);
    tick(); tick();
    check("pre_rst_drive", dq, 16'd3);
    #2 rst = 1'b1;
    #1 check("rst_async_dq", dq, Z16);
    tick();
    rst = 1'b0;
    check("rst_err_clear", {12'd0, proto_err, proto_err_code}, 16'd0);
    issue(C_RD, 2'd1, 12'h004);
    check("rst_bank_closed", {13'd0, proto_err_code}, 16'd2);
    issue(C_ACT, 2'd1, 12'h123);
    check("rst_mode_cleared", {13'd0, proto_err_code}, 16'd3);
    issue(C_RD, 2'd1, 12'h004);
    check("rst_cl2_n1_z", dq, Z16);
    tick(); check("rst_cl2_mem_kept", dq, 16'd3);
    tick(); check("rst_bl1_end_z", dq, Z16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
